// File: rtl/barrier_sequencer.sv
`default_nettype none
// =============================================================================
// barrier_sequencer : two-lane barrier command sequencer (open/close/clear/fault)
// barrier_lane      : one lane FSM with timer, reopen flag and sticky fault
// Revision: 1.0
// =============================================================================

module barrier_lane #(
   parameter int MOVE_TIMEOUT = 200,
   parameter int CLEAR_DELAY  = 20,
   parameter int PASS_TIMEOUT = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic request_i,
   input  logic sensor_i,
   input  logic barrier_i,
   input  logic emergency_i,
   input  logic fault_clear_i,
   output logic open_o,
   output logic close_o,
   output logic done_o,
   output logic busy_o,
   output logic fault_o,
   output logic accept_o
);

   localparam int MAX_LIMIT =
      (MOVE_TIMEOUT > CLEAR_DELAY)
         ? ((MOVE_TIMEOUT > PASS_TIMEOUT) ? MOVE_TIMEOUT : PASS_TIMEOUT)
         : ((CLEAR_DELAY  > PASS_TIMEOUT) ? CLEAR_DELAY  : PASS_TIMEOUT);
   localparam int TW = $clog2(MAX_LIMIT) + 1;

   localparam logic [TW-1:0] C_MOVE_LIM  = TW'(MOVE_TIMEOUT);
   localparam logic [TW-1:0] C_CLEAR_LIM = TW'(CLEAR_DELAY);
   localparam logic [TW-1:0] C_PASS_LIM  = TW'(PASS_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_OPENING     = 3'd1,
      S_WAIT_ARRIVE = 3'd2,
      S_WAIT_CLEAR  = 3'd3,
      S_HOLD        = 3'd4,
      S_CLOSING     = 3'd5,
      S_FAULT       = 3'd6,
      S_EMERG       = 3'd7
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            reopen_q, reopen_d;
   logic            fault_q, fault_d;
   logic            done_q, done_d;
   logic            nodone_q, nodone_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         reopen_q <= 1'b0;
         fault_q  <= 1'b0;
         done_q   <= 1'b0;
         nodone_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         reopen_q <= reopen_d;
         fault_q  <= fault_d;
         done_q   <= done_d;
         nodone_q <= nodone_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      reopen_d = reopen_q;
      fault_d  = fault_q;
      done_d   = 1'b0;
      nodone_d = nodone_q;
      accept_o = 1'b0;

      if (emergency_i) begin
         state_d  = S_EMERG;
         reopen_d = 1'b0;
      end else begin
         if (fault_clear_i) begin
            fault_d = 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (request_i) begin
                  state_d  = S_OPENING;
                  accept_o = 1'b1;
               end
            end
            S_OPENING: begin
               if (barrier_i) begin
                  state_d = S_WAIT_ARRIVE;
               end else if (timer_q == C_MOVE_LIM) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
               end
            end
            S_WAIT_ARRIVE: begin
               if (sensor_i) begin
                  state_d = S_WAIT_CLEAR;
               end else if (timer_q == C_PASS_LIM) begin
                  state_d = S_CLOSING;
               end
            end
            S_WAIT_CLEAR: begin
               if (!sensor_i) begin
                  state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               if (sensor_i) begin
                  state_d = S_WAIT_CLEAR;
               end else if (timer_q == C_CLEAR_LIM) begin
                  state_d  = S_CLOSING;
                  done_d   = !nodone_q;
                  nodone_d = 1'b0;
               end
            end
            S_CLOSING: begin
               // A vehicle seen under a closing barrier forces a reopen once it is down.
               if (sensor_i) begin
                  reopen_d = 1'b1;
               end
               if (!barrier_i) begin
                  state_d  = reopen_q ? S_OPENING : S_IDLE;
                  reopen_d = 1'b0;
               end else if (timer_q == C_MOVE_LIM) begin
                  state_d  = S_FAULT;
                  fault_d  = 1'b1;
                  reopen_d = 1'b0;
               end
            end
            S_FAULT: begin
               if (fault_clear_i) begin
                  state_d = S_IDLE;
               end
            end
            S_EMERG: begin
               state_d  = S_HOLD;
               nodone_d = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == {TW{1'b1}}) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   assign open_o  = (state_q == S_OPENING);
   assign close_o = (state_q == S_CLOSING);
   assign done_o  = done_q;
   assign busy_o  = (state_q != S_IDLE);
   assign fault_o = fault_q;

endmodule

module barrier_sequencer #(
   parameter int MOVE_TIMEOUT = 200,
   parameter int CLEAR_DELAY  = 20,
   parameter int PASS_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       entry_request,
   input  logic       exit_request,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   input  logic       entry_barrier,
   input  logic       exit_barrier,
   input  logic       emergency,
   input  logic       fault_clear,
   output logic       open_entry,
   output logic       close_entry,
   output logic       open_exit,
   output logic       close_exit,
   output logic       vehicle_direction,
   output logic       entry_done,
   output logic       exit_done,
   output logic       entry_busy,
   output logic       exit_busy,
   output logic [1:0] fault
);

   logic entry_accept;
   logic exit_accept;
   logic entry_fault;
   logic exit_fault;
   logic dir_q, dir_d;

   barrier_lane #(
      .MOVE_TIMEOUT (MOVE_TIMEOUT),
      .CLEAR_DELAY  (CLEAR_DELAY),
      .PASS_TIMEOUT (PASS_TIMEOUT)
   ) u_entry_lane (
      .clk           (clk),
      .reset_n       (reset_n),
      .request_i     (entry_request),
      .sensor_i      (entry_sensor),
      .barrier_i     (entry_barrier),
      .emergency_i   (emergency),
      .fault_clear_i (fault_clear),
      .open_o        (open_entry),
      .close_o       (close_entry),
      .done_o        (entry_done),
      .busy_o        (entry_busy),
      .fault_o       (entry_fault),
      .accept_o      (entry_accept)
   );

   barrier_lane #(
      .MOVE_TIMEOUT (MOVE_TIMEOUT),
      .CLEAR_DELAY  (CLEAR_DELAY),
      .PASS_TIMEOUT (PASS_TIMEOUT)
   ) u_exit_lane (
      .clk           (clk),
      .reset_n       (reset_n),
      .request_i     (exit_request),
      .sensor_i      (exit_sensor),
      .barrier_i     (exit_barrier),
      .emergency_i   (emergency),
      .fault_clear_i (fault_clear),
      .open_o        (open_exit),
      .close_o       (close_exit),
      .done_o        (exit_done),
      .busy_o        (exit_busy),
      .fault_o       (exit_fault),
      .accept_o      (exit_accept)
   );

   // Exit is checked last so it wins a same-cycle tie.
   always_comb begin
      dir_d = dir_q;
      if (entry_accept) begin
         dir_d = 1'b0;
      end
      if (exit_accept) begin
         dir_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_q <= 1'b0;
      end else begin
         dir_q <= dir_d;
      end
   end

   assign vehicle_direction = dir_q;
   assign fault             = {exit_fault, entry_fault};

endmodule
`default_nettype wire

// File: tb/tb_barrier_sequencer.sv
`default_nettype none
// Bench for barrier_sequencer: randomized lane scenarios against cycle predictions
// derived from the lane rules and a 3-cycle actuator model.
module tb_barrier_sequencer;

   localparam int MT  = 10;
   localparam int CD  = 4;
   localparam int PT  = 30;
   localparam int ACT = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] req = '0;
   logic [1:0] sens = '0;
   logic [1:0] fb = '0;
   logic [1:0] stuck = '0;
   logic       emergency = 1'b0;
   logic       fault_clear = 1'b0;

   logic       open_entry, close_entry, open_exit, close_exit;
   logic       vehicle_direction, entry_done, exit_done, entry_busy, exit_busy;
   logic [1:0] fault;

   logic [1:0] opn, cls, dn, bsy;
   assign opn = {open_exit, open_entry};
   assign cls = {close_exit, close_entry};
   assign dn  = {exit_done, entry_done};
   assign bsy = {exit_busy, entry_busy};

   int cyc = 0;
   int passes = 0;
   int checks = 0;

   barrier_sequencer #(
      .MOVE_TIMEOUT (MT),
      .CLEAR_DELAY  (CD),
      .PASS_TIMEOUT (PT)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .entry_request     (req[0]),
      .exit_request      (req[1]),
      .entry_sensor      (sens[0]),
      .exit_sensor       (sens[1]),
      .entry_barrier     (fb[0]),
      .exit_barrier      (fb[1]),
      .emergency         (emergency),
      .fault_clear       (fault_clear),
      .open_entry        (open_entry),
      .close_entry       (close_entry),
      .open_exit         (open_exit),
      .close_exit        (close_exit),
      .vehicle_direction (vehicle_direction),
      .entry_done        (entry_done),
      .exit_done         (exit_done),
      .entry_busy        (entry_busy),
      .exit_busy         (exit_busy),
      .fault             (fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Actuator: feedback follows a command held for ACT cycles; emergency forces open.
   int ocnt[2] = '{0, 0};
   int ccnt[2] = '{0, 0};
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fb <= '0;
         for (int l = 0; l < 2; l++) begin
            ocnt[l] <= 0;
            ccnt[l] <= 0;
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (emergency) begin
               fb[l]   <= 1'b1;
               ocnt[l] <= 0;
               ccnt[l] <= 0;
            end else begin
               ocnt[l] <= opn[l] ? ocnt[l] + 1 : 0;
               ccnt[l] <= cls[l] ? ccnt[l] + 1 : 0;
               if (opn[l] && (ocnt[l] + 1 >= ACT) && !stuck[l]) fb[l] <= 1'b1;
               if (cls[l] && (ccnt[l] + 1 >= ACT)) fb[l] <= 1'b0;
            end
         end
      end
   end

   // Event recorder: cycle numbers of edges and pulses per lane.
   int done_cnt[2]   = '{0, 0};
   int done_at[2]    = '{-1, -1};
   int open_rise[2]  = '{-1, -1};
   int open_rises[2] = '{0, 0};
   int close_rise[2] = '{-1, -1};
   int idle_at[2]    = '{-1, -1};
   logic [1:0] p_open = '0, p_close = '0, p_busy = '0;
   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (dn[l]) begin
            done_cnt[l] <= done_cnt[l] + 1;
            done_at[l]  <= cyc;
         end
         if (opn[l] && !p_open[l]) begin
            open_rise[l]  <= cyc;
            open_rises[l] <= open_rises[l] + 1;
         end
         if (cls[l] && !p_close[l]) close_rise[l] <= cyc;
         if (!bsy[l] && p_busy[l]) idle_at[l] <= cyc;
      end
      p_open  <= opn;
      p_close <= cls;
      p_busy  <= bsy;
   end

   task automatic goto(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_req(input logic [1:0] which, output int n);
      @(posedge clk);
      #1;
      n   = cyc;
      req = which;
      goto(n + 1);
      req = '0;
   endtask

   task automatic test_reset;
      logic [13:0] obs;
      obs = {opn, cls, vehicle_direction, dn, bsy, fault, fb, 1'b0};
      checks++;
      if (obs !== 14'd0) $display("FAIL reset_hold: got %b required 0", obs);
      else passes++;
      goto(cyc + 2);
      reset_n = 1'b1;
      goto(cyc + 2);
      obs = {opn, cls, vehicle_direction, dn, bsy, fault, fb, 1'b0};
      checks++;
      if (obs !== 14'd0) $display("FAIL reset_release: got %b required 0", obs);
      else passes++;
   endtask

   task automatic test_normal(input int l, input int d, input int h);
      int n, s, f, c, d0;
      d0 = done_cnt[l];
      pulse_req(2'(1 << l), n);
      checks++;
      if (opn[l] !== 1'b1) $display("FAIL normal_open_next lane%0d: got %b required 1", l, opn[l]);
      else passes++;
      s = n + 1 + ACT + 1 + d;
      goto(s);
      sens[l] = 1'b1;
      goto(s + h);
      sens[l] = 1'b0;
      f = s + h;
      c = f + 1 + CD + 1;
      goto(c + ACT + 2);
      checks++;
      if (done_cnt[l] - d0 !== 1) $display("FAIL normal_done_count lane%0d: got %0d required 1", l, done_cnt[l] - d0);
      else passes++;
      checks++;
      if (done_at[l] !== c) $display("FAIL normal_done_cycle lane%0d: got %0d required %0d", l, done_at[l], c);
      else passes++;
      checks++;
      if (close_rise[l] !== c) $display("FAIL normal_close_cycle lane%0d: got %0d required %0d", l, close_rise[l], c);
      else passes++;
      checks++;
      if (idle_at[l] !== c + ACT + 1) $display("FAIL normal_idle_cycle lane%0d: got %0d required %0d", l, idle_at[l], c + ACT + 1);
      else passes++;
      checks++;
      if ({bsy[l], opn[l], cls[l]} !== 3'b000) $display("FAIL normal_final lane%0d: got %b required 000", l, {bsy[l], opn[l], cls[l]});
      else passes++;
      checks++;
      if (vehicle_direction !== (l == 1)) $display("FAIL normal_direction lane%0d: got %b required %0d", l, vehicle_direction, l);
      else passes++;
   endtask

   task automatic test_no_show;
      int n, c, d0;
      d0 = done_cnt[0];
      pulse_req(2'b01, n);
      c = n + 1 + ACT + 1 + PT + 1;
      goto(c + ACT + 2);
      checks++;
      if (close_rise[0] !== c) $display("FAIL noshow_close_cycle: got %0d required %0d", close_rise[0], c);
      else passes++;
      checks++;
      if (done_cnt[0] !== d0) $display("FAIL noshow_no_done: got %0d required %0d", done_cnt[0], d0);
      else passes++;
      checks++;
      if (idle_at[0] !== c + ACT + 1 || entry_busy !== 1'b0) $display("FAIL noshow_idle: got %0d/%b required %0d/0", idle_at[0], entry_busy, c + ACT + 1);
      else passes++;
   endtask

   task automatic test_reopen(input int l, input int h, input int h2);
      int n, s, c, f2, c2, d0;
      d0 = done_cnt[l];
      pulse_req(2'(1 << l), n);
      s = n + 1 + ACT + 1;
      goto(s);
      sens[l] = 1'b1;
      goto(s + h);
      sens[l] = 1'b0;
      c = s + h + 1 + CD + 1;
      goto(c + 1);
      sens[l] = 1'b1;
      f2 = c + 1 + h2;
      goto(f2);
      sens[l] = 1'b0;
      c2 = f2 + 1 + CD + 1;
      checks++;
      if (open_rise[l] !== c + ACT + 1) $display("FAIL reopen_open_cycle lane%0d: got %0d required %0d", l, open_rise[l], c + ACT + 1);
      else passes++;
      goto(c2 + ACT + 2);
      checks++;
      if (done_cnt[l] - d0 !== 2) $display("FAIL reopen_done_count lane%0d: got %0d required 2", l, done_cnt[l] - d0);
      else passes++;
      checks++;
      if (done_at[l] !== c2) $display("FAIL reopen_done_cycle lane%0d: got %0d required %0d", l, done_at[l], c2);
      else passes++;
      checks++;
      if (idle_at[l] !== c2 + ACT + 1) $display("FAIL reopen_idle lane%0d: got %0d required %0d", l, idle_at[l], c2 + ACT + 1);
      else passes++;
   endtask

   task automatic test_stuck;
      int n;
      stuck = 2'b10;
      pulse_req(2'b10, n);
      goto(n + MT + 1);
      checks++;
      if ({fault, open_exit} !== 3'b001) $display("FAIL stuck_before: got %b required 001", {fault, open_exit});
      else passes++;
      goto(n + MT + 2);
      checks++;
      if ({fault, open_exit, exit_busy} !== 4'b1001) $display("FAIL stuck_fault: got %b required 1001", {fault, open_exit, exit_busy});
      else passes++;
      checks++;
      if (vehicle_direction !== 1'b1) $display("FAIL stuck_direction: got %b required 1", vehicle_direction);
      else passes++;
      goto(n + MT + 5);
      fault_clear = 1'b1;
      goto(n + MT + 6);
      fault_clear = 1'b0;
      stuck = 2'b00;
      checks++;
      if ({fault, exit_busy} !== 3'b000) $display("FAIL stuck_clear: got %b required 000", {fault, exit_busy});
      else passes++;
   endtask

   task automatic test_emergency(input int e);
      int n, r, c, d0, d1, o1;
      d0 = done_cnt[0];
      d1 = done_cnt[1];
      o1 = open_rises[1];
      pulse_req(2'b01, n);
      goto(n + 2);
      emergency = 1'b1;
      goto(n + 3);
      checks++;
      if ({opn, cls, bsy} !== 6'b000011) $display("FAIL emerg_cmds: got %b required 000011", {opn, cls, bsy});
      else passes++;
      goto(n + 4);
      req = 2'b10;
      goto(n + 5);
      req = 2'b00;
      r = n + 3 + e;
      goto(r);
      emergency = 1'b0;
      c = r + 1 + CD + 1;
      goto(c - 1);
      checks++;
      if (cls !== 2'b00) $display("FAIL emerg_early_close: got %b required 00", cls);
      else passes++;
      goto(c);
      checks++;
      if ({opn, cls} !== 4'b0011) $display("FAIL emerg_close: got %b required 0011", {opn, cls});
      else passes++;
      goto(c + ACT + 2);
      checks++;
      if (done_cnt[0] !== d0 || done_cnt[1] !== d1) $display("FAIL emerg_no_done: got %0d,%0d required %0d,%0d", done_cnt[0], done_cnt[1], d0, d1);
      else passes++;
      checks++;
      if (bsy !== 2'b00 || open_rises[1] !== o1) $display("FAIL emerg_idle: got %b/%0d required 00/%0d", bsy, open_rises[1], o1);
      else passes++;
      checks++;
      if (vehicle_direction !== 1'b0) $display("FAIL emerg_direction: got %b required 0", vehicle_direction);
      else passes++;
   endtask

   task automatic test_back_to_back;
      int n, c;
      logic [10:0] obs;
      pulse_req(2'b11, n);
      checks++;
      if ({opn, vehicle_direction} !== 3'b111) $display("FAIL b2b_open: got %b required 111", {opn, vehicle_direction});
      else passes++;
      c = n + 1 + ACT + 1 + PT + 1;
      goto(c + 1);
      checks++;
      if (cls !== 2'b11) $display("FAIL b2b_closing: got %b required 11", cls);
      else passes++;
      reset_n = 1'b0;
      #1;
      obs = {opn, cls, vehicle_direction, dn, bsy};
      checks++;
      if ({obs, fault} !== 13'd0) $display("FAIL b2b_async_reset: got %b required 0", {obs, fault});
      else passes++;
      goto(cyc + 2);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      for (int i = 0; i < 4; i++) begin
         test_normal(i % 2, int'($urandom_range(0, 5)), int'($urandom_range(1, 8)));
      end
      test_no_show();
      test_reopen(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)), int'($urandom_range(9, 14)));
      test_stuck();
      test_emergency(int'($urandom_range(3, 6)));
      test_back_to_back();
      goto(cyc + 3);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
